// File: rtl/cpu_pkg.sv
// Shared definitions for the 9-bit-ISA core.
// Contents:
//   seq_state_t   - instruction sequencer FSM states
//   instr_class_t - coarse instruction class used by the sequencer
//   HALT_INSTR    - the all-ones halt encoding
//   OP_*          - casez opcode patterns, also used by the instruction decoder
//   JUMP_TABLE    - program-specific jump targets, indexed by ir[3:0]
//   classify()    - maps a raw instruction word to its class
package cpu_pkg;

  localparam int INSTR_W = 9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_EXEC,
    S_MEM,
    S_HALT
  } seq_state_t;

  typedef enum logic [3:0] {
    I_NOP,
    I_HALT,
    I_MOV,
    I_CMP,
    I_ALU,
    I_JG,
    I_JGE,
    I_JMP,
    I_LDR,
    I_STR,
    I_LDI,
    I_STI
  } instr_class_t;

  localparam logic [INSTR_W-1:0] HALT_INSTR = 9'h1FF;

  // '?' bits are don't-care when the patterns are used as casez items.
  localparam logic [INSTR_W-1:0] OP_MOV    = 9'b000??????;
  localparam logic [INSTR_W-1:0] OP_CMP    = 9'b001??????;
  localparam logic [INSTR_W-1:0] OP_ALU2   = 9'b01???????;
  localparam logic [INSTR_W-1:0] OP_JG     = 9'b10000????;
  localparam logic [INSTR_W-1:0] OP_JGE    = 9'b10001????;
  localparam logic [INSTR_W-1:0] OP_JMP    = 9'b1001?????;
  localparam logic [INSTR_W-1:0] OP_LDR    = 9'b101110???;
  localparam logic [INSTR_W-1:0] OP_STR    = 9'b101111???;
  localparam logic [INSTR_W-1:0] OP_LDI    = 9'b110000???;
  localparam logic [INSTR_W-1:0] OP_STI    = 9'b110001???;
  localparam logic [INSTR_W-1:0] OP_ALU1   = 9'b101??????;

  // Jump targets for the current program; narrower PCs use the low bits.
  localparam logic [15:0] JUMP_TABLE [16] = '{
    16'h000, 16'h010, 16'h020, 16'h030, 16'h008, 16'h040, 16'h100, 16'h180,
    16'h200, 16'h280, 16'h300, 16'h380, 16'h3F0, 16'h0FF, 16'h1FE, 16'h3FF
  };

  // Order matters: ldr/str live inside the 101xxxxxx single-register ALU space
  // and must be matched before it.
  function automatic instr_class_t classify(input logic [INSTR_W-1:0] instr);
    if (instr == HALT_INSTR) return I_HALT;
    casez (instr)
      OP_MOV:  return I_MOV;
      OP_CMP:  return I_CMP;
      OP_ALU2: return I_ALU;
      OP_JG:   return I_JG;
      OP_JGE:  return I_JGE;
      OP_JMP:  return I_JMP;
      OP_LDR:  return I_LDR;
      OP_STR:  return I_STR;
      OP_LDI:  return I_LDI;
      OP_STI:  return I_STI;
      OP_ALU1: return I_ALU;
      default: return I_NOP;
    endcase
  endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Instruction-ROM and data-memory bus of the sequencer.
//   imem_addr  - instruction ROM address (sequencer -> ROM)
//   imem_data  - ROM data, valid the cycle after the address (ROM -> sequencer)
//   mem_req    - data-memory request, held until mem_ack
//   mem_we     - 1 = write, valid while mem_req
//   mem_ack    - one-cycle completion from data memory
// master: sequencer side; slave: memory side.
interface instr_sequencer_if
  import cpu_pkg::*;
#(
  parameter int PC_W = 10
);
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               mem_req;
  logic               mem_we;
  logic               mem_ack;

  modport master (
    output imem_addr, mem_req, mem_we,
    input  imem_data, mem_ack
  );

  modport slave (
    input  imem_addr, mem_req, mem_we,
    output imem_data, mem_ack
  );
endinterface

// File: rtl/jump_lut.sv
// Combinational 16-entry jump-target table.
//   idx    - ir[3:0] of the jump instruction
//   target - PC_W-bit jump target
module jump_lut
  import cpu_pkg::*;
#(
  parameter int PC_W = 10
) (
  input  logic [3:0]      idx,
  output logic [PC_W-1:0] target
);
  logic [15:0] raw;

  assign raw    = JUMP_TABLE[idx];
  assign target = PC_W'(raw);
endmodule

// File: rtl/instr_sequencer.sv
// Fetch/execute control unit: owns PC and IR, resolves jumps through the
// jump LUT, sequences multi-cycle memory ops, emits write strobes and status.
// Ports:
//   clk, rst_n           - clock, asynchronous active-low reset
//   start                - begin at PC 0 from IDLE/HALT
//   bus (master)         - instruction ROM and data-memory handshake
//   ir, pc               - instruction register, program counter
//   flag_gt, flag_eq     - ALU flags for conditional jumps
//   reg_we, flag_we      - one-cycle write strobes
//   busy, done, err      - run status (err = sticky memory timeout)
//   instr_count          - saturating retired-instruction counter
module instr_sequencer
  import cpu_pkg::*;
#(
  parameter int PC_W        = 10,
  parameter int MEM_TIMEOUT = 64,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  instr_sequencer_if.master   bus,
  output logic [INSTR_W-1:0]  ir,
  output logic [PC_W-1:0]     pc,
  input  logic                flag_gt,
  input  logic                flag_eq,
  output logic                reg_we,
  output logic                flag_we,
  output logic                busy,
  output logic                done,
  output logic                err,
  output logic [CNT_W-1:0]    instr_count
);
  localparam int TO_W = $clog2(MEM_TIMEOUT + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(MEM_TIMEOUT - 1);

  seq_state_t          state_q, state_d;
  logic [PC_W-1:0]     pc_q, pc_d;
  logic [INSTR_W-1:0]  ir_q, ir_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [TO_W-1:0]     tcnt_q, tcnt_d;
  logic                mem_req_q, mem_req_d;
  logic                mem_we_q, mem_we_d;
  logic                err_q, err_d;
  logic                done_q, done_d;
  logic                busy_q, busy_d;

  instr_class_t        cls;
  logic [PC_W-1:0]     jump_target;
  logic                retire;

  assign cls = classify(ir_q);

  jump_lut #(.PC_W(PC_W)) u_jump_lut (
    .idx    (ir_q[3:0]),
    .target (jump_target)
  );

  // Strobes are decoded from current state rather than registered: the load
  // write-back must coincide with the mem_ack cycle, which a flop cannot do.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves one unassigned (no latches).
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    cnt_d     = cnt_q;
    tcnt_d    = tcnt_q;
    mem_req_d = mem_req_q;
    mem_we_d  = mem_we_q;
    err_d     = err_q;
    retire    = 1'b0;
    reg_we    = 1'b0;
    flag_we   = 1'b0;

    case (state_q)
      S_IDLE, S_HALT: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
          err_d   = 1'b0;
          cnt_d   = '0;
        end
      end

      S_FETCH: state_d = S_LOAD;

      S_LOAD: begin
        ir_d    = bus.imem_data;
        state_d = S_EXEC;
      end

      S_EXEC: begin
        pc_d    = pc_q + 1'b1;   // wraps silently at 2^PC_W
        state_d = S_FETCH;
        retire  = 1'b1;
        case (cls)
          I_HALT: begin
            pc_d    = pc_q;
            state_d = S_HALT;
          end
          I_MOV, I_ALU: reg_we = 1'b1;
          I_CMP:        flag_we = 1'b1;
          I_JG:         if (flag_gt) pc_d = jump_target;
          I_JGE:        if (flag_gt || flag_eq) pc_d = jump_target;
          I_JMP:        pc_d = jump_target;
          I_LDR, I_LDI, I_STR, I_STI: begin
            // Retired only on ack; a timed-out access never counts.
            retire    = 1'b0;
            state_d   = S_MEM;
            mem_req_d = 1'b1;
            mem_we_d  = (cls == I_STR) || (cls == I_STI);
            tcnt_d    = '0;
          end
          default: ;
        endcase
      end

      S_MEM: begin
        // start is not looked at here, so a coincident start is ignored.
        if (bus.mem_ack) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          retire    = 1'b1;
          reg_we    = (cls == I_LDR) || (cls == I_LDI);
          state_d   = S_FETCH;
        end else if (tcnt_q == TO_LAST) begin
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          err_d     = 1'b1;
          state_d   = S_HALT;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (retire && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;

    done_d = (state_d == S_HALT);
    busy_d = (state_d != S_HALT) && (state_d != S_IDLE);
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      cnt_q     <= '0;
      tcnt_q    <= '0;
      mem_req_q <= 1'b0;
      mem_we_q  <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      cnt_q     <= cnt_d;
      tcnt_q    <= tcnt_d;
      mem_req_q <= mem_req_d;
      mem_we_q  <= mem_we_d;
      err_q     <= err_d;
      done_q    <= done_d;
      busy_q    <= busy_d;
    end
  end

  assign bus.imem_addr = pc_q;
  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign ir            = ir_q;
  assign pc            = pc_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign err           = err_q;
  assign instr_count   = cnt_q;

endmodule

// File: tb/tb_instr_sequencer.sv
// Directed testbench for instr_sequencer. A 10-bit-PC instance runs the main
// scenarios; a 4-bit-PC instance checks PC wrap-around.
// Cycle k = the clock period after the k-th rising edge following the
// negedge where start is raised (start is seen in IDLE/HALT during cycle 0).
module tb_instr_sequencer;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic start, start4;
  logic flag_gt, flag_eq;

  always #5 clk = ~clk;

  // ---------------- main instance, PC_W = 10 ----------------
  instr_sequencer_if #(.PC_W(10)) bus ();
  logic [8:0]  ir;
  logic [9:0]  pc;
  logic        reg_we, flag_we, busy, done, err;
  logic [15:0] instr_count;
  logic [8:0]  rom [1024];

  always @(posedge clk) bus.imem_data <= rom[bus.imem_addr];

  instr_sequencer #(.PC_W(10), .MEM_TIMEOUT(64), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .bus(bus),
    .ir(ir), .pc(pc), .flag_gt(flag_gt), .flag_eq(flag_eq),
    .reg_we(reg_we), .flag_we(flag_we), .busy(busy), .done(done),
    .err(err), .instr_count(instr_count)
  );

  // ---------------- wrap instance, PC_W = 4 ----------------
  instr_sequencer_if #(.PC_W(4)) bus4 ();
  logic [8:0]  ir4;
  logic [3:0]  pc4;
  logic        reg_we4, flag_we4, busy4, done4, err4;
  logic [15:0] instr_count4;
  logic [8:0]  rom4 [16];

  always @(posedge clk) bus4.imem_data <= rom4[bus4.imem_addr];

  instr_sequencer #(.PC_W(4), .MEM_TIMEOUT(64), .CNT_W(16)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .start(start4), .bus(bus4),
    .ir(ir4), .pc(pc4), .flag_gt(flag_gt), .flag_eq(flag_eq),
    .reg_we(reg_we4), .flag_we(flag_we4), .busy(busy4), .done(done4),
    .err(err4), .instr_count(instr_count4)
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  // Per-cycle traces of the main instance.
  logic [127:0] rw_tr, fw_tr, dn_tr, mr_tr, mwe_tr, er_tr;
  logic [9:0]   pc_tr [128];

  // Starts at a negedge: raises start for cycle 0, optionally pulses mem_ack
  // (and start again) in cycle ack_k, and records outputs for ncyc cycles.
  task automatic run_trace(input int ncyc, input int ack_k, input bit start_at_ack);
    rw_tr = '0; fw_tr = '0; dn_tr = '0; mr_tr = '0; mwe_tr = '0; er_tr = '0;
    for (int k = 0; k < ncyc; k++) begin
      start       = (k == 0) || (start_at_ack && (k == ack_k));
      bus.mem_ack = (k == ack_k);
      #1;
      rw_tr[k]  = reg_we;
      fw_tr[k]  = flag_we;
      dn_tr[k]  = done;
      mr_tr[k]  = bus.mem_req;
      mwe_tr[k] = bus.mem_we;
      er_tr[k]  = err;
      pc_tr[k]  = pc;
      @(negedge clk);
    end
    start       = 1'b0;
    bus.mem_ack = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; start4 = 1'b0;
    flag_gt = 1'b0; flag_eq = 1'b0;
    bus.mem_ack = 1'b0; bus4.mem_ack = 1'b0;
    for (int i = 0; i < 1024; i++) rom[i] = 9'h100;   // 100000000: jg idx0 filler
    for (int i = 0; i < 16; i++) rom4[i] = 9'b000_000_001; // mov

    // ---- reset values ----
    repeat (2) @(negedge clk);
    check("rst_pc",      pc, 0);
    check("rst_ir",      ir, 0);
    check("rst_busy",    busy, 0);
    check("rst_done",    done, 0);
    check("rst_err",     err, 0);
    check("rst_cnt",     instr_count, 0);
    check("rst_mem_req", bus.mem_req, 0);
    check("rst_strobes", {reg_we, flag_we}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // ---- straight line: mov, cmp, HALT ----
    // EXEC at cycles 3, 6, 9; HALT state (done) from cycle 10.
    rom[0] = 9'b000_010_011;
    rom[1] = 9'b001_000_001;
    rom[2] = HALT_INSTR;
    run_trace(12, -1, 1'b0);
    check("line_reg_we",  rw_tr[11:0], 12'h008);
    check("line_flag_we", fw_tr[11:0], 12'h040);
    check("line_done",    dn_tr[11:0], 12'hC00);
    check("line_cnt",     instr_count, 3);
    check("line_pc",      pc, 2);

    // ---- jge taken on eq: LUT[5] = 0x040 ----
    rom[0]    = 9'b10001_0101;
    rom[1]    = HALT_INSTR;
    rom[10'h040] = HALT_INSTR;
    flag_gt = 1'b0; flag_eq = 1'b1;
    run_trace(10, -1, 1'b0);
    check("jge_eq_pc",   pc_tr[4], 10'h040);
    check("jge_eq_done", dn_tr[9], 1);

    // ---- jge not taken with both flags clear ----
    flag_gt = 1'b0; flag_eq = 1'b0;
    run_trace(10, -1, 1'b0);
    check("jge_nt_pc",   pc_tr[4], 10'h001);
    check("jge_nt_done", dn_tr[9], 1);

    // ---- jg not taken on eq alone ----
    rom[0] = 9'b10000_0101;
    flag_gt = 1'b0; flag_eq = 1'b1;
    run_trace(10, -1, 1'b0);
    check("jg_eq_pc", pc_tr[4], 10'h001);

    // ---- jmp always taken: LUT[4] = 0x008 ----
    rom[0] = 9'b1001_00100;
    rom[8] = HALT_INSTR;
    flag_eq = 1'b0;
    run_trace(10, -1, 1'b0);
    check("jmp_pc", pc_tr[4], 10'h008);

    // ---- ldr, ack after 3 wait cycles; start coincident with ack ----
    // EXEC cycle 3, MEM cycles 4..7, ack in 7, FETCH of addr 1 in cycle 8.
    rom[0] = 9'b101110_001;
    rom[1] = HALT_INSTR;
    run_trace(13, 7, 1'b1);
    check("ldr_mem_req", mr_tr[12:0], 13'h00F0);
    check("ldr_mem_we",  mwe_tr[12:0], 0);
    check("ldr_reg_we",  rw_tr[12:0], 13'h0080);
    check("ldr_pc_next", pc_tr[8], 1);
    check("ldr_done",    dn_tr[12], 1);
    check("ldr_cnt",     instr_count, 2);

    // ---- sti timeout: MEM cycles 4..67, HALT from 68 ----
    rom[0] = 9'b110001_000;
    run_trace(72, -1, 1'b0);
    check("sti_req_cycles", $countones(mr_tr), 64);
    check("sti_req_last",   {mr_tr[68], mr_tr[67], mr_tr[3]}, 3'b010);
    check("sti_mem_we",     mwe_tr[4], 1);
    check("sti_err",        err, 1);
    check("sti_done",       done, 1);
    check("sti_req_low",    bus.mem_req, 0);
    check("sti_not_retired", instr_count, 0);

    // ---- restart clears err ----
    rom[0] = HALT_INSTR;
    run_trace(6, -1, 1'b0);
    check("restart_err",  {er_tr[1], er_tr[0]}, 2'b01);
    check("restart_pc",   pc_tr[1], 0);
    check("restart_done", dn_tr[1], 0);

    // ---- start while busy, then reset mid-MEM ----
    rom[0] = 9'b101110_010;
    run_trace(6, -1, 1'b0);          // now in cycle 6, MEM
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("busy_start_req", bus.mem_req, 1);
    check("busy_start_pc",  pc, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_req",  bus.mem_req, 0);
    check("midrst_pc",   pc, 0);
    check("midrst_busy", busy, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("midrst_idle", {busy, done}, 0);

    // ---- PC_W = 4 wrap: EXEC of addr 15 in cycle 48 ----
    for (int k = 0; k < 53; k++) begin
      start4 = (k == 0);
      #1;
      if (k == 48) check("wrap_pc15", pc4, 15);
      if (k == 49) begin
        check("wrap_pc0",  pc4, 0);
        check("wrap_cnt",  instr_count4, 16);
      end
      if (k == 52) check("wrap_pc1", pc4, 1);
      @(negedge clk);
    end
    check("wrap_busy", busy4, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
